// File: rtl/shift_cmd_fifo_if.sv
// Handshake bundle between a shift-command producer, the command queue and the
// downstream barrel shifter.
interface shift_cmd_fifo_if #(
  parameter int DW = 8,
  parameter int NW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_lr;
  logic [NW-1:0] in_n;
  logic          in_clear;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_lr;
  logic [NW-1:0] out_n;
  logic          out_clear;

  modport slave (
    input  in_valid, in_data, in_lr, in_n, in_clear, out_ready,
    output in_ready, out_valid, out_data, out_lr, out_n, out_clear
  );

  modport master (
    output in_valid, in_data, in_lr, in_n, in_clear, out_ready,
    input  in_ready, out_valid, out_data, out_lr, out_n, out_clear
  );
endinterface

// File: rtl/shift_cmd_fifo.sv
// First-word-fall-through command queue feeding the 8-bit barrel shifter.
// Occupancy is tracked in a counter so full/empty never depend on pointer equality.
module shift_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int NW    = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  shift_cmd_fifo_if.slave bus,
  output logic [CW-1:0]   count
);
  localparam int EW = DW + NW + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s, push_s, pop_s;
  logic [EW-1:0] head_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == CW'(0));
  assign push_s  = bus.in_valid && !full_s;
  assign pop_s   = bus.out_ready && !empty_s;
  assign head_s  = mem_q[rd_ptr_q];

  assign bus.in_ready  = !full_s;
  assign bus.out_valid = !empty_s;
  assign count         = count_q;

  // Head fields are zeroed while empty so unwritten storage never reaches the shifter.
  always_comb begin
    bus.out_data  = '0;
    bus.out_n     = '0;
    bus.out_lr    = 1'b0;
    bus.out_clear = 1'b0;
    if (!empty_s) begin
      bus.out_data  = head_s[DW-1:0];
      bus.out_n     = head_s[DW+NW-1:DW];
      bus.out_lr    = head_s[DW+NW];
      bus.out_clear = head_s[DW+NW+1];
    end else begin
      bus.out_data  = '0;
      bus.out_n     = '0;
      bus.out_lr    = 1'b0;
      bus.out_clear = 1'b0;
    end
  end

  // Next-state pointers and occupancy; pointer wrap is the natural power-of-two rollover.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; rst and flush both discard every entry and any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written verbatim and intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst && !flush) begin
      mem_q[wr_ptr_q] <= {bus.in_clear, bus.in_lr, bus.in_n, bus.in_data};
    end
  end
endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Directed self-checking bench for shift_cmd_fifo (DEPTH=4, DW=8, NW=3).
module tb_shift_cmd_fifo;
  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  int         vectors;
  int         errors;

  shift_cmd_fifo_if #(.DW(8), .NW(3)) bus ();

  shift_cmd_fifo #(.DEPTH(4), .DW(8), .NW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
    vectors++; if (bus.out_n !== 3'd0) begin errors++; $display("FAIL reset_out_n got %0d exp 0", bus.out_n); end
  endtask

  task automatic test_single_push();
    bus.in_lr    = 1'b1;
    bus.in_n     = 3'd3;
    bus.in_clear = 1'b0;
    push_one(8'hA5);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b exp 1", k, bus.out_valid); end
      vectors++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_data[%0d] got %h exp a5", k, bus.out_data); end
      vectors++; if (bus.out_lr !== 1'b1) begin errors++; $display("FAIL single_lr[%0d] got %b exp 1", k, bus.out_lr); end
      vectors++; if (bus.out_n !== 3'd3) begin errors++; $display("FAIL single_n[%0d] got %0d exp 3", k, bus.out_n); end
      vectors++; if (bus.out_clear !== 1'b0) begin errors++; $display("FAIL single_clear[%0d] got %b exp 0", k, bus.out_clear); end
      vectors++; if (count !== 3'd1) begin errors++; $display("FAIL single_count[%0d] got %0d exp 1", k, count); end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_popped_valid got %b exp 0", bus.out_valid); end
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL single_popped_count got %0d exp 0", count); end
  endtask

  task automatic test_full();
    logic [7:0] d;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      bus.in_n     = 3'(i);
      bus.in_clear = d[0];
      bus.in_lr    = d[1];
      push_one(d);
    end
    vectors++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
    push_one(8'h05);
    vectors++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignored_count got %0d exp 4", count); end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      vectors++; if (bus.out_data !== d) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.out_data, d); end
      vectors++; if (bus.out_n !== 3'(i)) begin errors++; $display("FAIL drain_n[%0d] got %0d exp %0d", i, bus.out_n, i); end
      vectors++; if (bus.out_clear !== d[0]) begin errors++; $display("FAIL drain_clear[%0d] got %b exp %b", i, bus.out_clear, d[0]); end
      vectors++; if (bus.out_lr !== d[1]) begin errors++; $display("FAIL drain_lr[%0d] got %b exp %b", i, bus.out_lr, d[1]); end
      step();
    end
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL drain_empty_data got %h exp 00", bus.out_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    bus.in_lr    = 1'b0;
    bus.in_n     = 3'd0;
    bus.in_clear = 1'b0;
    push_one(8'h10);
    push_one(8'h11);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_data = 8'h12 + 8'(k);
      e = 8'h10 + 8'(k);
      vectors++; if (bus.out_data !== e) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, bus.out_data, e); end
      step();
      vectors++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 2", k, count); end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = 8'h1A + 8'(k);
      vectors++; if (bus.out_data !== e) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", k, bus.out_data, e); end
      step();
    end
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] e;
    for (int i = 1; i <= 4; i++) push_one(8'h20 + 8'(i));
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h25;
    bus.out_ready = 1'b1;
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fpp_in_ready_before got %b exp 0", bus.in_ready); end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++; if (count !== 3'd3) begin errors++; $display("FAIL fpp_count got %0d exp 3", count); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fpp_in_ready_after got %b exp 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      e = 8'h20 + 8'(i);
      vectors++; if (bus.out_data !== e) begin errors++; $display("FAIL fpp_drain[%0d] got %h exp %h", i, bus.out_data, e); end
      step();
    end
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fpp_no_push got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_clear(input logic use_rst);
    for (int i = 0; i < 3; i++) push_one(8'h30 + 8'(i));
    vectors++; if (count !== 3'd3) begin errors++; $display("FAIL clr%0d_pre_count got %0d exp 3", use_rst, count); end
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL clr%0d_count got %0d exp 0", use_rst, count); end
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_valid got %b exp 0", use_rst, bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr%0d_in_ready got %b exp 1", use_rst, bus.in_ready); end
    push_one(8'h5A);
    vectors++; if (bus.out_data !== 8'h5A) begin errors++; $display("FAIL clr%0d_first got %h exp 5a", use_rst, bus.out_data); end
    vectors++; if (count !== 3'd1) begin errors++; $display("FAIL clr%0d_first_count got %0d exp 1", use_rst, count); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_end_valid got %b exp 0", use_rst, bus.out_valid); end
  endtask

  initial begin
    vectors       = 0;
    errors        = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_lr     = 1'b0;
    bus.in_n      = 3'd0;
    bus.in_clear  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_full();
    test_back_to_back();
    test_full_pop_push();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/shift_cmd_fifo.md
Name: shift_cmd_fifo

Overview:
- Command queue directly upstream of the team's 8-bit combinational barrel shifter.
- Buffers shift commands {data, lr, n, clear} from a bursty producer and presents them one at a time with a valid/ready handshake.
- Its out_* fields wire straight to the shifter's data_in/lr/n/clear inputs.
- First-word-fall-through, single clock.

Parameters:
- DEPTH, 4, number of command slots; power of two, >= 2.
- DW, 8, data width; must match the shifter data width.
- NW, 3, shift-amount width; clog2(DW).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear; all entries discarded.
- in_valid  input  1  producer has a command.
- in_ready  output  1  queue can accept; equals !full.
- in_data  input  DW  operand.
- in_lr  input  1  1 = left shift, 0 = right shift.
- in_n  input  NW  shift amount.
- in_clear  input  1  force-zero command.
- out_valid  output  1  head entry present; equals !empty.
- out_ready  input  1  consumer takes the head entry.
- out_data  output  DW  head operand.
- out_lr  output  1  head direction.
- out_n  output  NW  head shift amount.
- out_clear  output  1  head clear bit.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, in_ready = 1, out_valid = 0, all out_* fields = 0. Storage array is not reset.
- Entry format: {in_clear, in_lr, in_n, in_data}, DW+NW+2 bits, stored verbatim with no transformation.
- Push: occurs when in_valid && in_ready at the clock edge. Writes slot wr_ptr, then wr_ptr advances by 1 modulo DEPTH.
- Pop: occurs when out_valid && out_ready at the clock edge. rd_ptr advances by 1 modulo DEPTH.
- Latency: an entry pushed into an empty queue appears on out_* with out_valid = 1 in the cycle after the push edge. There is no combinational in-to-out bypass.
- out_* fields: driven combinationally from slot rd_ptr when !empty. Forced to 0 when empty; out_valid = 0 in that case.
- in_ready = (count != DEPTH), registered-state derived only, with no combinational path from out_ready. Consequence: when full, a same-cycle pop does not enable a push. in_ready rises the cycle after the pop.
- Simultaneous push and pop (0 < count < DEPTH): both take effect and count is unchanged.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows; handshake gating guarantees this.
- Pointer wrap-around: natural modulo DEPTH. full/empty come from count, not from pointer equality.
- flush: at the edge it resets wr_ptr, rd_ptr and count to 0. Takes priority over a same-cycle push and pop; both are discarded. Next cycle: out_valid = 0, in_ready = 1.
- rst mid-operation: same effect as flush, and also highest priority over everything.
- in_valid while !in_ready: input is ignored, with no state change. The producer must hold the command.
- No X propagation on outputs: the storage contents are only visible when they have been written.

Test Plan:
- Reset, then idle -> count = 0, in_ready = 1, out_valid = 0, out_data = 0x00, out_n = 0.
- Single push {data = 0xA5, lr = 1, n = 3, clear = 0} with out_ready = 0 -> next cycle out_valid = 1, out_data = 0xA5, out_lr = 1, out_n = 3, count = 1. Holds until out_ready = 1, then out_valid = 0 the following cycle.
- Push 4 entries 0x01..0x04 with out_ready = 0 -> count = 4, in_ready = 0. A 5th push of 0x05 is ignored. Draining with out_ready = 1 yields 0x01, 0x02, 0x03, 0x04 in order, then out_valid = 0.
- At count = 2, hold in_valid = 1 and out_ready = 1 for 10 cycles with incrementing data -> count stays 2, and output order equals input order across pointer wrap (at least 2 full wraps).
- Full queue with out_ready = 1 and in_valid = 1 in the same cycle -> pop occurs, push does not; count = 3, then in_ready = 1 next cycle.
- Queue holding 3 entries, assert flush together with in_valid = 1 -> next cycle count = 0, out_valid = 0. A subsequent push of 0x5A is the first entry out. The same sequence with rst instead of flush gives an identical result.
